// File: rtl/dv_test_sequencer.sv
`timescale 1ns/1ps
// Test-phase sequencer: IDLE -> WARMUP -> STIM -> DRAIN -> PASS/FAIL, with
// transaction accounting, drain-quiet detection and a watchdog.
module dv_test_sequencer #(
    parameter int unsigned WARMUP_CYCLES = 16,
    parameter int unsigned NUM_TXN       = 256,
    parameter int unsigned DRAIN_IDLE    = 32,
    parameter int unsigned TIMEOUT       = 50000,
    parameter int unsigned CW            = 32
) (
    input  logic          clk1,
    input  logic          nreset,
    input  logic          start,
    input  logic          stim_fire,
    input  logic          resp_fire,
    input  logic          dut_busy,
    input  logic          err,
    output logic          stim_en,
    output logic          stim_done,
    output logic          test_done,
    output logic          test_fail,
    output logic [1:0]    fail_code,
    output logic [2:0]    state,
    output logic [CW-1:0] txn_count,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        STIM   = 3'd2,
        DRAIN  = 3'd3,
        PASS   = 3'd4,
        FAIL   = 3'd5
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_ERR      = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_OVERFLOW = 2'd3;

    // A zero-length warm-up still spends one cycle in WARMUP.
    localparam int unsigned   WARMUP_LEN   = (WARMUP_CYCLES == 0) ? 1 : WARMUP_CYCLES;
    localparam logic [CW-1:0] WARMUP_LEN_C = CW'(WARMUP_LEN);
    localparam logic [CW-1:0] NUM_TXN_C    = CW'(NUM_TXN);
    localparam logic [CW-1:0] DRAIN_IDLE_C = CW'(DRAIN_IDLE);
    localparam logic [CW-1:0] TIMEOUT_C    = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE          = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] txn_q, txn_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] phase_q, phase_d;
    logic [CW-1:0] idle_q, idle_d;
    logic [1:0]    code_q, code_d;

    logic active;
    logic counted;
    logic overflow;
    logic timeout;
    logic quiet;

    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            txn_q   <= '0;
            cyc_q   <= '0;
            out_q   <= '0;
            phase_q <= '0;
            idle_q  <= '0;
            code_q  <= FC_NONE;
        end else begin
            txn_q   <= txn_d;
            cyc_q   <= cyc_d;
            out_q   <= out_d;
            phase_q <= phase_d;
            idle_q  <= idle_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        txn_d    = txn_q;
        cyc_d    = cyc_q;
        out_d    = out_q;
        phase_d  = phase_q;
        idle_d   = idle_q;
        code_d   = code_q;

        active   = (state_q == WARMUP) || (state_q == STIM) || (state_q == DRAIN);
        counted  = (state_q == STIM) && stim_fire;
        overflow = active && resp_fire && (out_q == '0) && !counted;
        quiet    = (out_q == '0) && !dut_busy;
        timeout  = 1'b0;

        // Counters advance in the cycle that triggers a verdict, then freeze.
        if (active) begin
            cyc_d   = cyc_q + ONE;
            timeout = (cyc_d >= TIMEOUT_C);
            if (counted) begin
                txn_d = txn_q + ONE;
            end
            if (counted && !resp_fire) begin
                out_d = out_q + ONE;
            end else if (!counted && resp_fire && (out_q != '0)) begin
                out_d = out_q - ONE;
            end
        end

        case (state_q)
            IDLE: begin
                txn_d   = '0;
                cyc_d   = '0;
                out_d   = '0;
                phase_d = '0;
                idle_d  = '0;
                code_d  = FC_NONE;
                if (start) begin
                    state_d = WARMUP;
                end
            end
            WARMUP: begin
                phase_d = phase_q + ONE;
                if (phase_d >= WARMUP_LEN_C) begin
                    state_d = STIM;
                end
            end
            STIM: begin
                if (counted && (txn_d == NUM_TXN_C)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                idle_d = quiet ? (idle_q + ONE) : '0;
                if (idle_d >= DRAIN_IDLE_C) begin
                    state_d = PASS;
                end
            end
            PASS, FAIL: begin
                state_d = state_q;
            end
            default: begin
                state_d = FAIL;
            end
        endcase

        if (active) begin
            if (err) begin
                state_d = FAIL;
                code_d  = FC_ERR;
            end else if (overflow) begin
                state_d = FAIL;
                code_d  = FC_OVERFLOW;
            end else if (timeout) begin
                state_d = FAIL;
                code_d  = FC_TIMEOUT;
            end
        end
    end

    always_comb begin
        state     = state_q;
        stim_en   = (state_q == STIM);
        stim_done = (state_q == DRAIN) || (state_q == PASS) || (state_q == FAIL);
        test_done = (state_q == PASS) || (state_q == FAIL);
        test_fail = (state_q == FAIL);
    end

    assign fail_code   = code_q;
    assign txn_count   = txn_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_dv_test_sequencer.sv
`timescale 1ns/1ps
// Bench for dv_test_sequencer: directed scenarios plus randomized traffic
// compared against a phase-level reference model.
module tb_dv_test_sequencer;

    localparam int P_WARMUP  = 4;
    localparam int P_NUM     = 8;
    localparam int P_DRAIN   = 5;
    localparam int P_TIMEOUT = 100;
    localparam int P_CW      = 16;

    logic clk1 = 1'b0;
    logic nreset, start, stim_fire, resp_fire, dut_busy, err;

    logic            stim_en, stim_done, test_done, test_fail;
    logic [1:0]      fail_code;
    logic [2:0]      state;
    logic [P_CW-1:0] txn_count, cycle_count;

    logic            stim_en0, stim_done0, test_done0, test_fail0;
    logic [1:0]      fail_code0;
    logic [2:0]      state0;
    logic [P_CW-1:0] txn_count0, cycle_count0;

    logic [40:0] dut_vec, dut_vec0;
    assign dut_vec  = {stim_en, stim_done, test_done, test_fail, fail_code, state, txn_count, cycle_count};
    assign dut_vec0 = {stim_en0, stim_done0, test_done0, test_fail0, fail_code0, state0, txn_count0, cycle_count0};

    dv_test_sequencer #(
        .WARMUP_CYCLES(P_WARMUP), .NUM_TXN(P_NUM), .DRAIN_IDLE(P_DRAIN),
        .TIMEOUT(P_TIMEOUT), .CW(P_CW)
    ) u_dut (
        .clk1(clk1), .nreset(nreset), .start(start), .stim_fire(stim_fire),
        .resp_fire(resp_fire), .dut_busy(dut_busy), .err(err),
        .stim_en(stim_en), .stim_done(stim_done), .test_done(test_done),
        .test_fail(test_fail), .fail_code(fail_code), .state(state),
        .txn_count(txn_count), .cycle_count(cycle_count)
    );

    dv_test_sequencer #(
        .WARMUP_CYCLES(0), .NUM_TXN(1), .DRAIN_IDLE(1),
        .TIMEOUT(P_TIMEOUT), .CW(P_CW)
    ) u_dut0 (
        .clk1(clk1), .nreset(nreset), .start(start), .stim_fire(stim_fire),
        .resp_fire(resp_fire), .dut_busy(dut_busy), .err(err),
        .stim_en(stim_en0), .stim_done(stim_done0), .test_done(test_done0),
        .test_fail(test_fail0), .fail_code(fail_code0), .state(state0),
        .txn_count(txn_count0), .cycle_count(cycle_count0)
    );

    always #5 clk1 = ~clk1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_now = 0;
    int pend[$];

    // Reference model: phase code (0 idle,1 warm,2 stim,3 drain,4 pass,5 fail) plus counts.
    int m_state, m_txn, m_cyc, m_out, m_warm, m_quiet, m_code;

    function automatic void model_clear();
        m_state = 0; m_txn = 0; m_cyc = 0; m_out = 0;
        m_warm = 0; m_quiet = 0; m_code = 0;
    endfunction

    function automatic logic [40:0] model_vec();
        logic [40:0] v;
        v = {m_state == 2, m_state >= 3, m_state >= 4, m_state == 5,
             2'(m_code), 3'(m_state), 16'(m_txn), 16'(m_cyc)};
        return v;
    endfunction

    task automatic model_step(input logic st, input logic sf, input logic rf,
                              input logic busy, input logic e);
        bit counted, overflow, quiet;
        int nxt, warm_len;
        warm_len = (P_WARMUP == 0) ? 1 : P_WARMUP;
        if (m_state == 0) begin
            model_clear();
            if (st) m_state = 1;
        end else if (m_state >= 1 && m_state <= 3) begin
            counted  = (m_state == 2) && sf;
            overflow = rf && (m_out == 0) && !counted;
            quiet    = (m_out == 0) && !busy;
            nxt      = m_state;
            m_cyc++;
            m_txn += int'(counted);
            m_out += int'(counted) - int'(rf && !overflow);
            if (m_state == 1) begin
                m_warm++;
                if (m_warm >= warm_len) nxt = 2;
            end
            if (m_state == 2 && m_txn == P_NUM) nxt = 3;
            if (m_state == 3) begin
                m_quiet = quiet ? m_quiet + 1 : 0;
                if (m_quiet >= P_DRAIN) nxt = 4;
            end
            if (e) begin
                nxt = 5; m_code = 1;
            end else if (overflow) begin
                nxt = 5; m_code = 3;
            end else if (m_cyc >= P_TIMEOUT) begin
                nxt = 5; m_code = 2;
            end
            m_state = nxt;
        end
    endtask

    task automatic tick(input logic sf, input logic rf, input logic busy, input logic e);
        stim_fire = sf; resp_fire = rf; dut_busy = busy; err = e;
        @(posedge clk1);
        model_step(start, sf, rf, busy, e);
        #1;
        cyc_now++;
    endtask

    task automatic pop_due(output logic rf);
        int idx;
        rf = 1'b0; idx = 0;
        for (int i = 0; i < pend.size(); i++) begin
            if (!rf && pend[i] <= cyc_now) begin
                rf = 1'b1; idx = i;
            end
        end
        if (rf) pend.delete(idx);
    endtask

    task automatic drive_cycle(input bit fire_ok, input bit busy, input bit e, input int lat);
        logic sf, rf;
        bit   cnt;
        int   now;
        sf  = fire_ok && stim_en;
        pop_due(rf);
        cnt = (m_state == 2) && sf;
        now = cyc_now;
        tick(sf, rf, busy, e);
        if (cnt) pend.push_back(now + lat);
    endtask

    task automatic do_reset();
        nreset = 1'b0; start = 1'b0;
        stim_fire = 1'b0; resp_fire = 1'b0; dut_busy = 1'b0; err = 1'b0;
        model_clear();
        pend.delete();
        repeat (2) @(posedge clk1);
        #1;
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; start = 1'b1;
        #1;
        n_tests++; if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_async got %h exp 0", dut_vec); end
        @(posedge clk1); #1;
        n_tests++; if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_held got %h exp 0", dut_vec); end
        n_tests++; if (dut_vec0 !== '0) begin n_fail++; $display("FAIL reset_held0 got %h exp 0", dut_vec0); end
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        n_tests++; if (state !== 3'd0 || txn_count !== '0) begin
            n_fail++; $display("FAIL idle_no_start got state %0d txn %0d exp 0 0", state, txn_count);
        end
    endtask

    task automatic test_nominal();
        int k, first_stim, en_cycles;
        do_reset(); start = 1'b1;
        k = 0; first_stim = -1; en_cycles = 0;
        while (k < 60 && !test_done) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 3);
            k++;
            n_tests++; if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL nominal_vec k=%0d got %h exp %h", k, dut_vec, model_vec());
            end
            if (stim_en) begin
                en_cycles++;
                if (first_stim < 0) first_stim = k;
            end
        end
        n_tests++; if (state !== 3'd4) begin n_fail++; $display("FAIL nominal_pass got %0d exp 4", state); end
        n_tests++; if (first_stim !== 5) begin n_fail++; $display("FAIL nominal_stim_start got %0d exp 5", first_stim); end
        n_tests++; if (en_cycles !== 8) begin n_fail++; $display("FAIL nominal_en_cycles got %0d exp 8", en_cycles); end
        n_tests++; if (txn_count !== 16'd8 || test_fail !== 1'b0 || fail_code !== 2'd0) begin
            n_fail++; $display("FAIL nominal_final got txn %0d fail %0d code %0d exp 8 0 0", txn_count, test_fail, fail_code);
        end
    endtask

    task automatic test_drain_restart();
        int k, after;
        bit pulsed, busy;
        do_reset(); start = 1'b1;
        k = 0; after = -1; pulsed = 0;
        while (k < 60 && !test_done) begin
            busy = 0;
            if (!pulsed && m_state == 3 && m_quiet == 4) begin
                busy = 1; pulsed = 1; after = 0;
            end else if (pulsed) begin
                after++;
            end
            drive_cycle(1'b1, busy, 1'b0, 3);
            k++;
            n_tests++; if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL restart_vec k=%0d got %h exp %h", k, dut_vec, model_vec());
            end
            if (after == 4) begin
                n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL restart_early got %0d exp 3", state); end
            end
        end
        n_tests++; if (!pulsed || after !== 5 || state !== 3'd4) begin
            n_fail++; $display("FAIL restart_pass got after %0d state %0d exp 5 4", after, state);
        end
    endtask

    task automatic test_error();
        int k, f3;
        logic [40:0] exp_v;
        do_reset(); start = 1'b1;
        k = 0;
        while (k < 20 && !stim_en) begin tick(1'b0, 1'b0, 1'b0, 1'b0); k++; end
        n_tests++; if (stim_en !== 1'b1) begin n_fail++; $display("FAIL error_reach_stim got %0d exp 1", stim_en); end
        drive_cycle(1'b1, 1'b0, 1'b0, 3);
        drive_cycle(1'b1, 1'b0, 1'b0, 3);
        f3 = int'($urandom_range(0, 1));
        drive_cycle(f3 != 0, 1'b0, 1'b1, 3);
        exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 3'd5, 16'(2 + f3), 16'd7};
        n_tests++; if (dut_vec !== exp_v) begin n_fail++; $display("FAIL error_verdict got %h exp %h", dut_vec, exp_v); end
        repeat (6) begin
            start = 1'($urandom_range(0, 1));
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        n_tests++; if (dut_vec !== exp_v) begin n_fail++; $display("FAIL error_frozen got %h exp %h", dut_vec, exp_v); end
    endtask

    task automatic test_watchdog();
        int k;
        do_reset(); start = 1'b1;
        k = 0;
        while (k < 120 && !test_done) begin tick(1'b0, 1'b0, 1'b0, 1'b0); k++; end
        n_tests++; if (k !== 101) begin n_fail++; $display("FAIL watchdog_cycles got %0d exp 101", k); end
        n_tests++; if (state !== 3'd5 || fail_code !== 2'd2 || cycle_count !== 16'd100) begin
            n_fail++; $display("FAIL watchdog_verdict got st %0d code %0d cyc %0d exp 5 2 100", state, fail_code, cycle_count);
        end
    endtask

    task automatic test_overflow();
        int k;
        do_reset(); start = 1'b1;
        k = 0;
        while (k < 20 && !stim_en) begin tick(1'b1, 1'b0, 1'b0, 1'b0); k++; end
        n_tests++; if (stim_en !== 1'b1 || txn_count !== '0) begin
            n_fail++; $display("FAIL ovf_ignore_fire got en %0d txn %0d exp 1 0", stim_en, txn_count);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 3'd2 || txn_count !== 16'd1) begin
            n_fail++; $display("FAIL ovf_fire_and_resp got st %0d txn %0d exp 2 1", state, txn_count);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 3'd5 || fail_code !== 2'd3 || txn_count !== 16'd1) begin
            n_fail++; $display("FAIL ovf_verdict got st %0d code %0d txn %0d exp 5 3 1", state, fail_code, txn_count);
        end
    endtask

    task automatic test_priority();
        for (int run = 0; run < 2; run++) begin
            do_reset(); start = 1'b1;
            repeat (100) tick(1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++; if (state !== 3'd2 || cycle_count !== 16'd99) begin
                n_fail++; $display("FAIL prio_pre run%0d got st %0d cyc %0d exp 2 99", run, state, cycle_count);
            end
            tick(1'b0, run == 1, 1'b0, run == 0);
            n_tests++; if (state !== 3'd5 || fail_code !== ((run == 0) ? 2'd1 : 2'd3) || cycle_count !== 16'd100) begin
                n_fail++; $display("FAIL prio_timeout run%0d got st %0d code %0d cyc %0d exp 5 %0d 100",
                                   run, state, fail_code, cycle_count, (run == 0) ? 1 : 3);
            end
        end
        do_reset(); start = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        n_tests++; if (state !== 3'd5 || fail_code !== 2'd1) begin
            n_fail++; $display("FAIL prio_err_ovf got st %0d code %0d exp 5 1", state, fail_code);
        end
    endtask

    task automatic test_reset_mid_stim();
        int k;
        do_reset(); start = 1'b1;
        k = 0;
        while (k < 40 && txn_count != 16'd5) begin drive_cycle(1'b1, 1'b0, 1'b0, 3); k++; end
        n_tests++; if (txn_count !== 16'd5 || state !== 3'd2) begin
            n_fail++; $display("FAIL midrst_reach got txn %0d st %0d exp 5 2", txn_count, state);
        end
        #2 nreset = 1'b0;
        #1;
        n_tests++; if (dut_vec !== '0) begin n_fail++; $display("FAIL midrst_async got %h exp 0", dut_vec); end
        model_clear();
        pend.delete();
        @(posedge clk1); #1;
        n_tests++; if (dut_vec !== '0) begin n_fail++; $display("FAIL midrst_held got %h exp 0", dut_vec); end
        nreset = 1'b1;
        k = 0;
        while (k < 80 && !test_done) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 3);
            k++;
            n_tests++; if (dut_vec !== model_vec()) begin
                n_fail++; $display("FAIL midrst_vec k=%0d got %h exp %h", k, dut_vec, model_vec());
            end
        end
        n_tests++; if (state !== 3'd4 || txn_count !== 16'd8) begin
            n_fail++; $display("FAIL midrst_pass got st %0d txn %0d exp 4 8", state, txn_count);
        end
    endtask

    task automatic test_zero_warmup();
        logic [40:0] exp_v;
        do_reset(); start = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (state0 !== 3'd1) begin n_fail++; $display("FAIL zw_warmup got %0d exp 1", state0); end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (state0 !== 3'd2 || stim_en0 !== 1'b1) begin
            n_fail++; $display("FAIL zw_stim got st %0d en %0d exp 2 1", state0, stim_en0);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++; if (state0 !== 3'd3 || txn_count0 !== 16'd1) begin
            n_fail++; $display("FAIL zw_drain got st %0d txn %0d exp 3 1", state0, txn_count0);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (state0 !== 3'd3) begin n_fail++; $display("FAIL zw_not_quiet got %0d exp 3", state0); end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd4, 16'd1, 16'd4};
        n_tests++; if (dut_vec0 !== exp_v) begin n_fail++; $display("FAIL zw_pass got %h exp %h", dut_vec0, exp_v); end
    endtask

    task automatic test_random();
        logic sf, rf, busy, e;
        bit   cnt;
        int   k, post, now;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            repeat ($urandom_range(0, 3)) tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            start = 1'b1;
            k = 0; post = 0;
            while (k < 160 && post < 3) begin
                sf   = stim_en ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                pop_due(rf);
                if (!rf) rf = ($urandom_range(0, 199) == 0);
                busy = ($urandom_range(0, 7) == 0);
                e    = ($urandom_range(0, 399) == 0);
                cnt  = (m_state == 2) && sf;
                now  = cyc_now;
                tick(sf, rf, busy, e);
                if (cnt) pend.push_back(now + int'($urandom_range(1, 5)));
                k++;
                n_tests++; if (dut_vec !== model_vec()) begin
                    n_fail++; $display("FAIL random_vec r=%0d k=%0d got %h exp %h", r, k, dut_vec, model_vec());
                end
                if (m_state >= 4) post++;
            end
        end
    endtask

    initial begin
        nreset = 1'b1; start = 1'b0;
        stim_fire = 1'b0; resp_fire = 1'b0; dut_busy = 1'b0; err = 1'b0;
        model_clear();
        #3;
        test_reset();
        test_nominal();
        test_drain_restart();
        test_error();
        test_watchdog();
        test_overflow();
        test_priority();
        test_reset_mid_stim();
        test_zero_warmup();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/dv_test_sequencer.md
# dv_test_sequencer

Synchronous test-phase sequencer for the simulation control environment. After the control block raises `start`, it walks warm-up, stimulus, drain and verdict phases. It gates the stimulus generator, counts issued and returned transactions, and runs a watchdog. It produces the `stim_done`, `test_done` and pass/fail status that end the simulation.

## Interface
- WARMUP_CYCLES, 16, idle cycles after `start` before stimulus is enabled (0 allowed)
- NUM_TXN, 256, transactions to issue (must be ≥1)
- DRAIN_IDLE, 32, consecutive quiet cycles required to declare pass (must be ≥1)
- TIMEOUT, 50000, watchdog limit in clk1 cycles, counted from leaving IDLE
- CW, 32, width of all counters
- clk1  in  1  sequencer clock
- nreset  in  1  reset, asynchronous, active-low
- start  in  1  level; test may begin
- stim_fire  in  1  generator issued one transaction this cycle
- resp_fire  in  1  one response retired this cycle
- dut_busy  in  1  DUT reports internal activity
- err  in  1  checker mismatch, sampled every cycle
- stim_en  out  1  generator may issue (decode of state==STIM)
- stim_done  out  1  stimulus phase finished
- test_done  out  1  verdict reached
- test_fail  out  1  verdict is fail
- fail_code  out  2  0 none, 1 err, 2 timeout, 3 response overflow
- state  out  3  current FSM state
- txn_count  out  CW  transactions issued
- cycle_count  out  CW  watchdog count

## Operation
- States:
  - IDLE=0
  - WARMUP=1
  - STIM=2
  - DRAIN=3
  - PASS=4
  - FAIL=5
  - Codes 6–7 are unreachable and must go to FAIL.
- IDLE: when `start`=1, go to WARMUP. Clear all counters.
- WARMUP: a phase counter counts clk1 cycles. After WARMUP_CYCLES cycles in WARMUP, go to STIM. If WARMUP_CYCLES=0, WARMUP lasts exactly one cycle.
- STIM: `stim_en`=1.
  - Each `stim_fire` increments `txn_count` and the outstanding counter.
  - The fire that makes `txn_count`=NUM_TXN moves the FSM to DRAIN on the next edge.
  - `stim_fire` outside STIM is ignored and not counted.
- DRAIN:
  - The idle counter increments on each cycle where outstanding==0 and `dut_busy`=0.
  - Any other cycle clears the idle counter to 0.
  - When the idle counter reaches DRAIN_IDLE, go to PASS.
- Outstanding counter:
  - `resp_fire` decrements it in any non-terminal state.
  - Simultaneous `stim_fire` (counted) and `resp_fire` leaves it unchanged.
  - `resp_fire` with outstanding==0 and no counted fire in the same cycle → FAIL, fail_code=3.
- `err`=1 in WARMUP, STIM or DRAIN → FAIL, fail_code=1.
- Watchdog: `cycle_count` increments every cycle outside IDLE and the terminal states. Reaching TIMEOUT → FAIL, fail_code=2.
- Same-cycle priority: err > response overflow > timeout > normal transition.
- PASS and FAIL are terminal until `nreset`. Counters freeze and later inputs are ignored.
- Outputs:
  - `stim_done` = state ∈ {DRAIN, PASS, FAIL}
  - `test_done` = state ∈ {PASS, FAIL}
  - `test_fail` = state==FAIL
- `fail_code` is registered with the FAIL entry and holds.

## Timing
- Reset: asynchronous. state=IDLE. `txn_count`, `cycle_count`, `fail_code`, and the outstanding, phase and idle counters are all 0. `stim_en`, `stim_done`, `test_done` and `test_fail` are 0.
- Assertion of `nreset` mid-test aborts immediately to IDLE with the values above, with no verdict.
- `start` sampled at edge t → WARMUP at t+1 → STIM at t+1+max(WARMUP_CYCLES,1).
- `stim_en` is a decode of registered state:
  - It is high from the first STIM cycle.
  - It drops the cycle after the final counted fire.
  - It never stays high with `txn_count`=NUM_TXN for more than the cycle of that fire.
- PASS is entered the edge after the DRAIN_IDLE-th consecutive quiet cycle. The minimum DRAIN length is DRAIN_IDLE cycles.
- FAIL is entered on the edge after the offending sample. The outputs reflect FAIL one cycle after `err`, overflow or timeout.
- Counters wrap only if CW is too narrow. An integrator must size CW ≥ clog2(max(TIMEOUT, NUM_TXN)+1).

## Test plan
- Nominal pass:
  - Stimulus: WARMUP_CYCLES=4, NUM_TXN=8, DRAIN_IDLE=5. Generator fires every cycle; each response returns 3 cycles later; `dut_busy`=0.
  - Required response: `stim_en` for 8 cycles, `txn_count`=8, `stim_done` after the 8th fire, PASS, `test_fail`=0, `fail_code`=0.
- Drain restart:
  - Stimulus: as nominal, with `dut_busy` pulsed for 1 cycle at idle count 4.
  - Required response: idle counter clears; PASS comes exactly 5 quiet cycles after the pulse.
- Error injection:
  - Stimulus: `err`=1 on the 3rd STIM cycle.
  - Required response: FAIL next cycle, `fail_code`=1, `test_done`=1, `stim_en`=0, `txn_count` frozen at 2 or 3 according to fires.
- Watchdog:
  - Stimulus: TIMEOUT=100, generator never fires.
  - Required response: FAIL at `cycle_count`=100, `fail_code`=2.
- Overflow and priority:
  - Stimulus: a `resp_fire` with 0 outstanding gives `fail_code`=3. In a separate run, `err` and timeout in the same cycle.
  - Required response: the first run ends in FAIL with `fail_code`=3; the second run gives `fail_code`=1.
- Reset mid-STIM:
  - Stimulus: drop `nreset` after 5 fires, release it, hold `start`=1.
  - Required response: all outputs 0 and IDLE during reset, then a clean rerun to PASS.
